// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: I-cache, D-cache and physical-memory line-port bundle
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              arb_busy;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata, arb_busy
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata, arb_busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises I-cache and D-cache line transfers onto one memory port
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the D-cache wins ties.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input logic clk,
    input logic rst,
    cache_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
    state_t state, next;
    logic wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic d_req, grant_d;
    assign d_req = bus.d_read | bus.d_write;
`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last;
    assign grant_d = d_req & (~bus.i_read | ~rr_last);
    // remember who was granted last so a tie goes to the other side (1 = D)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_last <= 1'b0;
        else if (state == IDLE && (d_req | bus.i_read)) rr_last <= grant_d;
    end
`else
    assign grant_d = d_req;
`endif
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= next;
    end
    // arbitrate in IDLE, wait for memory in SERVE, one dead cycle in RELEASE
    always_comb begin
        next = state;
        case (state)
            IDLE:             next = grant_d ? SERVE_D : bus.i_read ? SERVE_I : IDLE;
            SERVE_I, SERVE_D: next = bus.pmem_resp ? RELEASE : state;
            default:          next = IDLE;
        endcase
    end
    // latch the winner's request at grant so later input changes are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr  <= '0;
            wdata <= '0;
            wr    <= 1'b0;
        end else if (state == IDLE && next != IDLE) begin
            addr <= grant_d ? bus.d_addr : bus.i_addr;
            wr   <= grant_d & bus.d_write;
            if (grant_d) wdata <= bus.d_wdata;
        end
    end
    assign bus.pmem_read  = (state == SERVE_I) | (state == SERVE_D & ~wr);
    assign bus.pmem_write = (state == SERVE_D) & wr;
    assign bus.pmem_addr  = addr;
    assign bus.pmem_wdata = wdata;
    assign bus.i_resp     = (state == SERVE_I) & bus.pmem_resp;
    assign bus.d_resp     = (state == SERVE_D) & bus.pmem_resp;
    assign bus.i_rdata    = bus.i_resp ? bus.pmem_rdata : '0;
    assign bus.d_rdata    = bus.d_resp ? bus.pmem_rdata : '0;
    assign bus.arb_busy   = state != IDLE;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bench with a transaction-level arbiter model
module tb_cache_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    cache_mem_arbiter_if bus ();
    cache_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [255:0] PAT = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] AB  = {32{8'hAB}};

    // model: a transaction is either absent, in service, or cooling down one cycle
    bit busy_m, cool_m, own_d, m_wr, last_d;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    bit glog[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_m = 0;
            cool_m = 0;
            last_d = 0;
        end else if (cool_m) begin
            cool_m = 0;
        end else if (busy_m) begin
            if (bus.pmem_resp) begin
                busy_m = 0;
                cool_m = 1;
            end
        end else if (bus.i_read | bus.d_read | bus.d_write) begin
`ifdef ARB_ROUND_ROBIN_EN
            own_d = (bus.d_read | bus.d_write) && !(bus.i_read && last_d);
`else
            own_d = bus.d_read | bus.d_write;
`endif
            last_d  = own_d;
            m_wr    = own_d && bus.d_write;
            m_addr  = own_d ? bus.d_addr : bus.i_addr;
            m_wdata = bus.d_wdata;
            glog.push_back(own_d);
            busy_m  = 1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // per-cycle comparison against the model, then advance to just after the next edge
    task automatic tick;
        logic ir, dr;
        @(negedge clk);
        ir = busy_m && !own_d && bus.pmem_resp;
        dr = busy_m && own_d && bus.pmem_resp;
        chk("pmem_read", bus.pmem_read, busy_m && !m_wr);
        chk("pmem_write", bus.pmem_write, busy_m && m_wr);
        chk("arb_busy", bus.arb_busy, busy_m || cool_m);
        chk("i_resp", bus.i_resp, ir);
        chk("d_resp", bus.d_resp, dr);
        chk("i_rdata", bus.i_rdata, ir ? bus.pmem_rdata : '0);
        chk("d_rdata", bus.d_rdata, dr ? bus.pmem_rdata : '0);
        if (busy_m) chk("pmem_addr", bus.pmem_addr, m_addr);
        if (busy_m && m_wr) chk("pmem_wdata", bus.pmem_wdata, m_wdata);
        @(posedge clk);
        #1;
    endtask

    // memory model: answer the current strobe after lat cycles
    task automatic mem_respond(input int lat, input logic [255:0] data, input bit exp_d);
        int n = 0;
        while (!(bus.pmem_read | bus.pmem_write) && n < 50) begin
            tick();
            n++;
        end
        chk("strobe_timeout", n < 50, 1);
        repeat (lat - 1) tick();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = data;
        #1;
        chk("owner_resp", exp_d ? bus.d_resp : bus.i_resp, 1);
        chk("owner_rdata", exp_d ? bus.d_rdata : bus.i_rdata, data);
        chk("other_resp", exp_d ? bus.i_resp : bus.d_resp, 0);
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
    endtask

    initial begin
        bit first_d;
        logic [7:0] packed_log;
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0040;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
        tick();
        tick();
        chk("rst_busy", bus.arb_busy, 0);
        chk("rst_read", bus.pmem_read, 0);
        chk("rst_addr", bus.pmem_addr, 0);
        rst = 1'b1;
        tick();
        chk("i_grant_read", bus.pmem_read, 1);
        chk("i_grant_addr", bus.pmem_addr, 32'h0000_0040);
        mem_respond(5, AB, 0);
        bus.i_read = 1'b0;
        tick();
        chk("i_done_idle", bus.arb_busy, 0);

        bus.d_write = 1'b1; bus.d_addr = 32'h8000_0020; bus.d_wdata = PAT;
        tick();
        chk("wb_write", bus.pmem_write, 1);
        chk("wb_read", bus.pmem_read, 0);
        chk("wb_addr", bus.pmem_addr, 32'h8000_0020);
        chk("wb_wdata", bus.pmem_wdata, PAT);
        mem_respond(3, {32{8'h5A}}, 1);
        chk("wb_release_busy", bus.arb_busy, 1);
        chk("wb_release_write", bus.pmem_write, 0);
        bus.d_write = 1'b0;
        tick();
        chk("wb_idle", bus.arb_busy, 0);

`ifdef ARB_ROUND_ROBIN_EN
        first_d = 0;
`else
        first_d = 1;
`endif
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0100;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0200;
        tick();
        chk("tie_first_addr", bus.pmem_addr, first_d ? 32'h200 : 32'h100);
        mem_respond(2, {32{8'h11}}, first_d);
        if (first_d) bus.d_read = 1'b0; else bus.i_read = 1'b0;
        tick();
        chk("tie_idle_gap", bus.arb_busy, 0);
        tick();
        chk("tie_second_addr", bus.pmem_addr, first_d ? 32'h100 : 32'h200);
        mem_respond(2, {32{8'h22}}, !first_d);
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        tick();

        bus.i_read = 1'b1; bus.d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            mem_respond(2, {32{k[7:0]}}, k % 2 == 1);
`else
            mem_respond(2, {32{k[7:0]}}, 1);
`endif
        end
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        tick();
        tick();
        chk("glog_size", glog.size(), 8);
        packed_log = '0;
        for (int k = 0; k < 8 && k < glog.size(); k++) packed_log[k] = glog[k];
`ifdef ARB_ROUND_ROBIN_EN
        chk("grant_order", packed_log, 8'hAA);
`else
        chk("grant_order", packed_log, 8'hF6);
`endif

        bus.pmem_resp = 1'b1; bus.pmem_rdata = AB;
        #1;
        chk("stray_i_resp", bus.i_resp, 0);
        chk("stray_d_resp", bus.d_resp, 0);
        chk("stray_i_rdata", bus.i_rdata, 0);
        tick();
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
        chk("stray_idle", bus.arb_busy, 0);

        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h0000_0300; bus.d_wdata = ~PAT;
        tick();
        chk("rw_write", bus.pmem_write, 1);
        chk("rw_read", bus.pmem_read, 0);
        chk("rw_wdata", bus.pmem_wdata, ~PAT);
        mem_respond(1, {32{8'h33}}, 1);
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        tick();

        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0400;
        tick();
        bus.i_read = 1'b0;
        mem_respond(3, {32{8'h44}}, 0);
        tick();
        tick();

        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0500;
        tick();
        bus.d_addr = 32'h0000_0600;
        tick();
        chk("mid_addr_hold", bus.pmem_addr, 32'h0000_0500);
        chk("mid_read", bus.pmem_read, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_read", bus.pmem_read, 0);
        chk("mid_rst_busy", bus.arb_busy, 0);
        bus.d_read = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", bus.arb_busy, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
